// File: rtl/regfile_port_arbiter.sv
// Two-port arbiter in front of a 32x32 dual-read / single-write register file.
// Port A (core datapath) and port B (debug/load) compete for the file; the
// winner's command is latched, one READ or WRITE strobe cycle is issued, and
// completion is signalled with a one-cycle DONE pulse on the winning port.
// Every output is a flop; the next-state logic computes all of them at once.

module regfile_port_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIXED_PRIO   = 0,  // 0: round-robin, 1: port A always wins
    parameter int unsigned ZERO_PROTECT = 1   // 1: writes to register 0 are dropped
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_a_i,
    input  logic              req_b_i,
    input  logic              we_a_i,
    input  logic              we_b_i,
    input  logic [ADDR_W-1:0] ra1_a_i,
    input  logic [ADDR_W-1:0] ra2_a_i,
    input  logic [ADDR_W-1:0] ra1_b_i,
    input  logic [ADDR_W-1:0] ra2_b_i,
    input  logic [ADDR_W-1:0] wa_a_i,
    input  logic [ADDR_W-1:0] wa_b_i,
    input  logic [DATA_W-1:0] wd_a_i,
    input  logic [DATA_W-1:0] wd_b_i,
    output logic              gnt_a_o,
    output logic              gnt_b_o,
    output logic              done_a_o,
    output logic              done_b_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              rf_read_o,
    output logic              rf_write_o,
    output logic [ADDR_W-1:0] rf_addr_r1_o,
    output logic [ADDR_W-1:0] rf_addr_r2_o,
    output logic [ADDR_W-1:0] rf_addr_w_o,
    output logic [DATA_W-1:0] rf_data_w_o,
    input  logic [DATA_W-1:0] rf_data_r1_i,
    input  logic [DATA_W-1:0] rf_data_r2_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    // Port identifiers used for winner and last_grant tracking.
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_e              state_q, state_d;
    logic                gnt_a_q, gnt_a_d;
    logic                gnt_b_q, gnt_b_d;
    logic                done_a_q, done_a_d;
    logic                done_b_q, done_b_d;
    logic                rf_read_q, rf_read_d;
    logic                rf_write_q, rf_write_d;
    logic [ADDR_W-1:0]   addr_r1_q, addr_r1_d;
    logic [ADDR_W-1:0]   addr_r2_q, addr_r2_d;
    logic [ADDR_W-1:0]   addr_w_q, addr_w_d;
    logic [DATA_W-1:0]   data_w_q, data_w_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic [DATA_W-1:0]   rdata2_q, rdata2_d;
    logic                winner_q, winner_d;      // port holding the current command
    logic                we_q, we_d;              // latched command type
    logic                last_grant_q, last_grant_d;
    logic                pick_b;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_wa;

    // Next-state and next-output logic for arbitration and strobe sequencing.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d      = state_q;
        gnt_a_d      = 1'b0;
        gnt_b_d      = 1'b0;
        done_a_d     = 1'b0;
        done_b_d     = 1'b0;
        rf_read_d    = 1'b0;
        rf_write_d   = 1'b0;
        addr_r1_d    = addr_r1_q;
        addr_r2_d    = addr_r2_q;
        addr_w_d     = addr_w_q;
        data_w_d     = data_w_q;
        rdata1_d     = rdata1_q;
        rdata2_d     = rdata2_q;
        winner_d     = winner_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        pick_b       = 1'b0;
        sel_we       = 1'b0;
        sel_wa       = '0;

        case (state_q)
            S_IDLE: begin
                if (req_a_i || req_b_i) begin
                    // B wins when alone, or on a tie in round-robin mode after A was served.
                    pick_b = req_b_i &&
                             (!req_a_i || ((FIXED_PRIO == 0) && (last_grant_q == PORT_A)));
                    sel_we = pick_b ? we_b_i : we_a_i;
                    sel_wa = pick_b ? wa_b_i : wa_a_i;

                    winner_d   = pick_b ? PORT_B : PORT_A;
                    we_d       = sel_we;
                    addr_r1_d  = pick_b ? ra1_b_i : ra1_a_i;
                    addr_r2_d  = pick_b ? ra2_b_i : ra2_a_i;
                    addr_w_d   = sel_wa;
                    data_w_d   = pick_b ? wd_b_i : wd_a_i;
                    gnt_a_d    = !pick_b;
                    gnt_b_d    = pick_b;
                    rf_read_d  = !sel_we;
                    // A protected write to register 0 still runs the full handshake.
                    rf_write_d = sel_we && !((ZERO_PROTECT != 0) && (sel_wa == '0));
                    state_d    = S_ACCESS;
                end
            end

            S_ACCESS: begin
                done_a_d     = (winner_q == PORT_A);
                done_b_d     = (winner_q == PORT_B);
                if (!we_q) begin
                    rdata1_d = rf_data_r1_i;
                    rdata2_d = rf_data_r2_i;
                end
                last_grant_d = winner_q;
                state_d      = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q      <= S_IDLE;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            done_a_q     <= 1'b0;
            done_b_q     <= 1'b0;
            rf_read_q    <= 1'b0;
            rf_write_q   <= 1'b0;
            addr_r1_q    <= '0;
            addr_r2_q    <= '0;
            addr_w_q     <= '0;
            data_w_q     <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            winner_q     <= PORT_A;
            we_q         <= 1'b0;
            last_grant_q <= PORT_B;   // A wins the first tie after reset
        end else begin
            state_q      <= state_d;
            gnt_a_q      <= gnt_a_d;
            gnt_b_q      <= gnt_b_d;
            done_a_q     <= done_a_d;
            done_b_q     <= done_b_d;
            rf_read_q    <= rf_read_d;
            rf_write_q   <= rf_write_d;
            addr_r1_q    <= addr_r1_d;
            addr_r2_q    <= addr_r2_d;
            addr_w_q     <= addr_w_d;
            data_w_q     <= data_w_d;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rdata2_d;
            winner_q     <= winner_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign gnt_a_o      = gnt_a_q;
    assign gnt_b_o      = gnt_b_q;
    assign done_a_o     = done_a_q;
    assign done_b_o     = done_b_q;
    assign rdata1_o     = rdata1_q;
    assign rdata2_o     = rdata2_q;
    assign rf_read_o    = rf_read_q;
    assign rf_write_o   = rf_write_q;
    assign rf_addr_r1_o = addr_r1_q;
    assign rf_addr_r2_o = addr_r2_q;
    assign rf_addr_w_o  = addr_w_q;
    assign rf_data_w_o  = data_w_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter. Instance 0 runs round-robin,
// instance 1 runs fixed priority; each has its own behavioural register file.
module tb_regfile_port_arbiter;

    logic        clk;
    logic        rst;
    logic        req_a [2];
    logic        req_b [2];
    logic        we_a [2];
    logic        we_b [2];
    logic [4:0]  ra1_a [2];
    logic [4:0]  ra2_a [2];
    logic [4:0]  ra1_b [2];
    logic [4:0]  ra2_b [2];
    logic [4:0]  wa_a [2];
    logic [4:0]  wa_b [2];
    logic [31:0] wd_a [2];
    logic [31:0] wd_b [2];
    logic        gnt_a [2];
    logic        gnt_b [2];
    logic        done_a [2];
    logic        done_b [2];
    logic [31:0] rdata1 [2];
    logic [31:0] rdata2 [2];
    logic        rf_read [2];
    logic        rf_write [2];
    logic [4:0]  rf_addr_r1 [2];
    logic [4:0]  rf_addr_r2 [2];
    logic [4:0]  rf_addr_w [2];
    logic [31:0] rf_data_w [2];
    logic [31:0] rf_data_r1 [2];
    logic [31:0] rf_data_r2 [2];

    int vectors;
    int miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mem [32];

        regfile_port_arbiter #(
            .DATA_W(32), .ADDR_W(5), .FIXED_PRIO(g), .ZERO_PROTECT(1)
        ) dut (
            .clk_i(clk), .rst_i(rst),
            .req_a_i(req_a[g]), .req_b_i(req_b[g]),
            .we_a_i(we_a[g]), .we_b_i(we_b[g]),
            .ra1_a_i(ra1_a[g]), .ra2_a_i(ra2_a[g]),
            .ra1_b_i(ra1_b[g]), .ra2_b_i(ra2_b[g]),
            .wa_a_i(wa_a[g]), .wa_b_i(wa_b[g]),
            .wd_a_i(wd_a[g]), .wd_b_i(wd_b[g]),
            .gnt_a_o(gnt_a[g]), .gnt_b_o(gnt_b[g]),
            .done_a_o(done_a[g]), .done_b_o(done_b[g]),
            .rdata1_o(rdata1[g]), .rdata2_o(rdata2[g]),
            .rf_read_o(rf_read[g]), .rf_write_o(rf_write[g]),
            .rf_addr_r1_o(rf_addr_r1[g]), .rf_addr_r2_o(rf_addr_r2[g]),
            .rf_addr_w_o(rf_addr_w[g]), .rf_data_w_o(rf_data_w[g]),
            .rf_data_r1_i(rf_data_r1[g]), .rf_data_r2_i(rf_data_r2[g])
        );

        // Behavioural register file; undriven read data is a marker value so a
        // capture outside the READ strobe is visible.
        initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        always @(posedge clk) if (rf_write[g]) mem[rf_addr_w[g]] <= rf_data_w[g];
        assign rf_data_r1[g] = rf_read[g] ? mem[rf_addr_r1[g]] : 32'hBAD0_BAD0;
        assign rf_data_r2[g] = rf_read[g] ? mem[rf_addr_r2[g]] : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int p, input logic req, input logic we, input logic [4:0] ra1,
                         input logic [4:0] ra2, input logic [4:0] wa, input logic [31:0] wd);
        req_a[p] = req; we_a[p] = we; ra1_a[p] = ra1; ra2_a[p] = ra2; wa_a[p] = wa; wd_a[p] = wd;
    endtask

    task automatic set_b(input int p, input logic req, input logic we, input logic [4:0] ra1,
                         input logic [4:0] ra2, input logic [4:0] wa, input logic [31:0] wd);
        req_b[p] = req; we_b[p] = we; ra1_b[p] = ra1; ra2_b[p] = ra2; wa_b[p] = wa; wd_b[p] = wd;
    endtask

    // Mutual-exclusion properties checked every cycle on both instances.
    always @(negedge clk) begin
        for (int p = 0; p < 2; p++) begin
            check("gnt_excl", 32'(gnt_a[p] & gnt_b[p]), 32'h0);
            check("done_excl", 32'(done_a[p] & done_b[p]), 32'h0);
            check("strobe_excl", 32'(rf_read[p] & rf_write[p]), 32'h0);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int p = 0; p < 2; p++) begin
            set_a(p, 0, 0, 0, 0, 0, 0);
            set_b(p, 0, 0, 0, 0, 0, 0);
        end

        // Reset for two cycles; all outputs must be zero.
        rst = 1'b1;
        tick();
        tick();
        check("rst_gnt", {30'b0, gnt_a[0], gnt_b[0]}, 32'h0);
        check("rst_done", {30'b0, done_a[0], done_b[0]}, 32'h0);
        check("rst_strobe", {30'b0, rf_read[0], rf_write[0]}, 32'h0);
        check("rst_addr", {17'b0, rf_addr_r1[0], rf_addr_r2[0], rf_addr_w[0]}, 32'h0);
        check("rst_wdata", rf_data_w[0], 32'h0);
        check("rst_rdata1", rdata1[0], 32'h0);
        check("rst_rdata2", rdata2[0], 32'h0);
        rst = 1'b0;

        // Single write from A: GNT with WRITE strobe, then DONE.
        set_a(0, 1, 1, 0, 0, 5'd5, 32'hDEADBEEF);
        tick();
        check("wr_gnt_a", 32'(gnt_a[0]), 32'h1);
        check("wr_strobe", {30'b0, rf_read[0], rf_write[0]}, 32'h1);
        check("wr_addr_w", 32'(rf_addr_w[0]), 32'h5);
        check("wr_data_w", rf_data_w[0], 32'hDEADBEEF);
        check("wr_no_done", 32'(done_a[0]), 32'h0);
        set_a(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("wr_done_a", {done_a[0], gnt_a[0], rf_write[0]}, 32'h4);
        tick();

        // Read back reg 5 and reg 0 from A.
        set_a(0, 1, 0, 5'd5, 5'd0, 0, 0);
        tick();
        check("rd_gnt_a", 32'(gnt_a[0]), 32'h1);
        check("rd_strobe", {30'b0, rf_read[0], rf_write[0]}, 32'h2);
        check("rd_addr", {rf_addr_r1[0], rf_addr_r2[0]}, 32'h0A0);
        set_a(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rd_done_a", 32'(done_a[0]), 32'h1);
        check("rd_rdata1", rdata1[0], 32'hDEADBEEF);
        check("rd_rdata2", rdata2[0], 32'h0);
        tick();

        // Reset during the ACCESS cycle of a read: no DONE, RDATA cleared.
        set_a(0, 1, 0, 5'd5, 5'd5, 0, 0);
        tick();
        check("abort_gnt", 32'(gnt_a[0]), 32'h1);
        set_a(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_done", {30'b0, done_a[0], done_b[0]}, 32'h0);
        check("abort_strobe", 32'(rf_read[0]), 32'h0);
        check("abort_rdata1", rdata1[0], 32'h0);
        check("abort_rdata2", rdata2[0], 32'h0);

        // Round-robin with both ports held: A,B,A,B, one access every 3 cycles.
        set_a(0, 1, 1, 0, 0, 5'd7, 32'h11111111);
        set_b(0, 1, 1, 0, 0, 5'd8, 32'h22222222);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", {30'b0, gnt_a[0], gnt_b[0]}, (k % 2 == 0) ? 32'h2 : 32'h1);
            check("rr_addr_w", 32'(rf_addr_w[0]), (k % 2 == 0) ? 32'h7 : 32'h8);
            tick();
            check("rr_done", {30'b0, done_a[0], done_b[0]}, (k % 2 == 0) ? 32'h2 : 32'h1);
            tick();
        end
        set_a(0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0);

        // Fixed priority on instance 1: A always wins while held, then B.
        set_a(1, 1, 1, 0, 0, 5'd3, 32'hA5A5A5A5);
        set_b(1, 1, 1, 0, 0, 5'd4, 32'h5A5A5A5A);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("fp_gnt", {30'b0, gnt_a[1], gnt_b[1]}, 32'h2);
            tick();
            check("fp_done", {30'b0, done_a[1], done_b[1]}, 32'h2);
            tick();
        end
        set_a(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("fp_gnt_b", {30'b0, gnt_a[1], gnt_b[1]}, 32'h1);
        set_b(1, 0, 0, 0, 0, 0, 0);
        tick();
        check("fp_done_b", {30'b0, done_a[1], done_b[1]}, 32'h1);
        tick();

        // Zero protect: B writes reg 0, handshake completes without a strobe.
        set_b(0, 1, 1, 0, 0, 5'd0, 32'h1);
        tick();
        check("zp_gnt_b", 32'(gnt_b[0]), 32'h1);
        check("zp_strobe", {30'b0, rf_read[0], rf_write[0]}, 32'h0);
        set_b(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("zp_done_b", 32'(done_b[0]), 32'h1);
        tick();
        set_b(0, 1, 0, 5'd0, 5'd8, 0, 0);
        tick();
        check("zp_rd_gnt_b", 32'(gnt_b[0]), 32'h1);
        set_b(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("zp_rd_done_b", 32'(done_b[0]), 32'h1);
        check("zp_rdata1", rdata1[0], 32'h0);
        check("zp_rdata2", rdata2[0], 32'h22222222);
        tick();

        // Held REQ_A through DONE: second access granted 2 cycles after DONE.
        set_a(0, 1, 1, 0, 0, 5'd9, 32'h33333333);
        tick();
        check("hold_gnt1", 32'(gnt_a[0]), 32'h1);
        tick();
        check("hold_done1", 32'(done_a[0]), 32'h1);
        check("hold_rdata1", rdata1[0], 32'h0);
        check("hold_rdata2", rdata2[0], 32'h22222222);
        tick();
        check("hold_idle", {30'b0, gnt_a[0], done_a[0]}, 32'h0);
        tick();
        check("hold_gnt2", 32'(gnt_a[0]), 32'h1);
        set_a(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("hold_done2", 32'(done_a[0]), 32'h1);
        tick();
        check("hold_quiet", {28'b0, gnt_a[0], gnt_b[0], done_a[0], done_b[0]}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
